// File: rtl/key_edit_pkg.sv
// Shared definitions for the key pad front-end and the field editor:
// one-hot key codes, editor states and the decoded key event codes.
package key_edit_pkg;

  localparam logic [4:0] KEY_MENU   = 5'b10000;
  localparam logic [4:0] KEY_SET    = 5'b01000;
  localparam logic [4:0] KEY_CANCEL = 5'b00100;
  localparam logic [4:0] KEY_UP     = 5'b00010;
  localparam logic [4:0] KEY_DOWN   = 5'b00001;

  typedef enum logic {
    ST_IDLE,
    ST_EDIT
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_MENU,
    EV_SET,
    EV_CANCEL,
    EV_UP,
    EV_DOWN
  } event_t;

  // Any value that is not exactly one key maps to EV_NONE.
  function automatic event_t key_to_event(input logic [4:0] key);
    case (key)
      KEY_MENU:   return EV_MENU;
      KEY_SET:    return EV_SET;
      KEY_CANCEL: return EV_CANCEL;
      KEY_UP:     return EV_UP;
      KEY_DOWN:   return EV_DOWN;
      default:    return EV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key pad front-end: 2-flop synchroniser, stability counter and release
// tracking. Emits a one-cycle event code per accepted press.
// Optional feature: define AUTO_REPEAT_EN to make held UP/DOWN keys
// repeat after REPEAT_DLY cycles and then every REPEAT_RATE cycles.
module key_debounce
  import key_edit_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_DLY   = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key,
  output event_t     evt
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [4:0]       key_s1;
  logic [4:0]       key_s2;
  logic [4:0]       key_last;
  logic [CNT_W-1:0] stable_cnt;
  logic             pressed;
  logic             stable_done;

  // key_last has held its value long enough to be trusted.
  assign stable_done = (key_s2 == key_last) &&
                       (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1));

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic [REP_W-1:0] rep_limit;

  // First repeat waits the long delay, later ones the short rate.
  assign rep_limit = rep_first ? REP_W'(REPEAT_DLY - 1) : REP_W'(REPEAT_RATE - 1);
`else
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = 32'(REPEAT_DLY) ^ 32'(REPEAT_RATE);
`endif

  // Two-flop synchroniser for the asynchronous key pins.
  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // Stability counter, press acceptance, release tracking and repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_last   <= '0;
      stable_cnt <= '0;
      pressed    <= 1'b0;
      evt        <= EV_NONE;
`ifdef AUTO_REPEAT_EN
      rep_cnt    <= '0;
      rep_first  <= 1'b0;
`endif
    end else begin
      evt <= EV_NONE;
      if (key_s2 != key_last) begin
        key_last   <= key_s2;
        stable_cnt <= '0;
      end else if (!stable_done) begin
        stable_cnt <= stable_cnt + 1'b1;
      end else if (!pressed) begin
        // Only a single stable key counts as a press.
        if (key_to_event(key_last) != EV_NONE) begin
          evt     <= key_to_event(key_last);
          pressed <= 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_cnt   <= '0;
          rep_first <= 1'b1;
`endif
        end
      end else if (key_last == '0) begin
        pressed <= 1'b0;
`ifdef AUTO_REPEAT_EN
      end else if (key_last == KEY_UP || key_last == KEY_DOWN) begin
        if (rep_cnt == rep_limit) begin
          evt       <= key_to_event(key_last);
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/key_field_editor.sv
// Generic field editor for clock/date/alarm setting. Snapshots the live
// counter values on SET, edits the selected field with per-field min/max
// wrap, and reports commit, abort or idle-mode key events.
// Optional feature: define AUTO_REPEAT_EN for held UP/DOWN auto-repeat
// (implemented inside key_debounce).
module key_field_editor
  import key_edit_pkg::*;
#(
  parameter int NUM_FIELDS   = 6,
  parameter int FIELD_W      = 7,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int REPEAT_DLY   = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic [4:0]                      KEY,
  input  logic [NUM_FIELDS*FIELD_W-1:0]   IN_VALUES,
  input  logic [NUM_FIELDS*FIELD_W-1:0]   FIELD_MIN,
  input  logic [NUM_FIELDS*FIELD_W-1:0]   FIELD_MAX,
  output logic [NUM_FIELDS*FIELD_W-1:0]   OUT_VALUES,
  output logic [$clog2(NUM_FIELDS)-1:0]   FIELD_SEL,
  output logic                            EDIT_ACTIVE,
  output logic                            COMMIT,
  output logic                            ABORT,
  output logic                            MENU_EVT,
  output logic                            ALT_EVT
);

  localparam int SEL_W = $clog2(NUM_FIELDS);
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef logic [FIELD_W-1:0] field_t;

  event_t          evt;
  state_t          state;
  logic [TO_W-1:0] to_cnt;
  field_t          in_f  [NUM_FIELDS];
  field_t          min_f [NUM_FIELDS];
  field_t          max_f [NUM_FIELDS];
  field_t          work  [NUM_FIELDS];
  field_t          sel_val;
  field_t          sel_min;
  field_t          sel_max;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DLY   (REPEAT_DLY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_debounce (
    .clk   (CLK),
    .rst_n (RESETN),
    .key   (KEY),
    .evt   (evt)
  );

  // Unpack the flat buses into per-field views and repack the working set.
  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_fields
    assign in_f[i]  = IN_VALUES[i*FIELD_W +: FIELD_W];
    assign min_f[i] = FIELD_MIN[i*FIELD_W +: FIELD_W];
    assign max_f[i] = FIELD_MAX[i*FIELD_W +: FIELD_W];
    assign OUT_VALUES[i*FIELD_W +: FIELD_W] = work[i];
  end

  assign sel_val = work[FIELD_SEL];
  assign sel_min = min_f[FIELD_SEL];
  assign sel_max = max_f[FIELD_SEL];

  // Out-of-range snapshots start at min (also covers min > max).
  function automatic field_t clamp_field(input field_t v, input field_t mn, input field_t mx);
    return (v < mn || v > mx) ? mn : v;
  endfunction

  // Increment with wrap; a field with min > max is pinned at min.
  function automatic field_t wrap_up(input field_t v, input field_t mn, input field_t mx);
    if (mn > mx)  return mn;
    if (v >= mx)  return mn;
    return v + 1'b1;
  endfunction

  // Decrement with wrap; never steps below min, so no underflow.
  function automatic field_t wrap_down(input field_t v, input field_t mn, input field_t mx);
    if (mn > mx)  return mn;
    if (v <= mn)  return mx;
    return v - 1'b1;
  endfunction

  // Editor FSM with registered pulses, working registers and idle timeout.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= ST_IDLE;
      FIELD_SEL   <= '0;
      EDIT_ACTIVE <= 1'b0;
      COMMIT      <= 1'b0;
      ABORT       <= 1'b0;
      MENU_EVT    <= 1'b0;
      ALT_EVT     <= 1'b0;
      to_cnt      <= '0;
      // NOTE: the working set is a small register array, not a RAM, so it
      // can and does take a defined reset value.
      for (int i = 0; i < NUM_FIELDS; i++) work[i] <= '0;
    end else begin
      COMMIT   <= 1'b0;
      ABORT    <= 1'b0;
      MENU_EVT <= 1'b0;
      ALT_EVT  <= 1'b0;
      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          for (int i = 0; i < NUM_FIELDS; i++)
            work[i] <= (evt == EV_SET) ? clamp_field(in_f[i], min_f[i], max_f[i]) : in_f[i];
          case (evt)
            EV_SET: begin
              FIELD_SEL   <= '0;
              state       <= ST_EDIT;
              EDIT_ACTIVE <= 1'b1;
            end
            EV_MENU:   MENU_EVT <= 1'b1;
            EV_CANCEL: ALT_EVT  <= 1'b1;
            default: ;
          endcase
        end
        ST_EDIT: begin
          if (evt != EV_NONE) begin
            to_cnt <= '0;
            case (evt)
              EV_MENU:
                FIELD_SEL <= (FIELD_SEL == SEL_W'(NUM_FIELDS - 1)) ? '0 : FIELD_SEL + 1'b1;
              EV_UP:   work[FIELD_SEL] <= wrap_up(sel_val, sel_min, sel_max);
              EV_DOWN: work[FIELD_SEL] <= wrap_down(sel_val, sel_min, sel_max);
              EV_SET: begin
                COMMIT      <= 1'b1;
                state       <= ST_IDLE;
                EDIT_ACTIVE <= 1'b0;
              end
              EV_CANCEL: begin
                ABORT       <= 1'b1;
                state       <= ST_IDLE;
                EDIT_ACTIVE <= 1'b0;
              end
              default: ;
            endcase
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            to_cnt      <= '0;
            ABORT       <= 1'b1;
            state       <= ST_IDLE;
            EDIT_ACTIVE <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_field_editor.sv
// Directed self-checking bench for key_field_editor with small timing
// parameters (debounce 4, timeout 50, three 6-bit fields).
module tb_key_field_editor;

  localparam int NF = 3;
  localparam int FW = 6;
  localparam int VW = NF * FW;

  localparam logic [4:0] K_MENU   = 5'b10000;
  localparam logic [4:0] K_SET    = 5'b01000;
  localparam logic [4:0] K_CANCEL = 5'b00100;
  localparam logic [4:0] K_UP     = 5'b00010;
  localparam logic [4:0] K_DOWN   = 5'b00001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    key;
  logic [VW-1:0] in_values;
  logic [VW-1:0] field_min;
  logic [VW-1:0] field_max;
  logic [VW-1:0] out_values;
  logic [1:0]    field_sel;
  logic          edit_active;
  logic          commit;
  logic          abort;
  logic          menu_evt;
  logic          alt_evt;

  int n_checks = 0;
  int n_pass   = 0;

  int            commit_cnt;
  int            abort_cnt;
  int            menu_cnt;
  int            alt_cnt;
  int            commit_f0;
  logic          abort_prev;
  logic [VW-1:0] after_abort;

  key_field_editor #(
    .NUM_FIELDS   (NF),
    .FIELD_W      (FW),
    .DEBOUNCE_CYC (4),
    .TIMEOUT_CYC  (50),
    .REPEAT_DLY   (10),
    .REPEAT_RATE  (3)
  ) dut (
    .CLK         (clk),
    .RESETN      (rst_n),
    .KEY         (key),
    .IN_VALUES   (in_values),
    .FIELD_MIN   (field_min),
    .FIELD_MAX   (field_max),
    .OUT_VALUES  (out_values),
    .FIELD_SEL   (field_sel),
    .EDIT_ACTIVE (edit_active),
    .COMMIT      (commit),
    .ABORT       (abort),
    .MENU_EVT    (menu_evt),
    .ALT_EVT     (alt_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int fld(input logic [VW-1:0] v, input int i);
    return int'(v[i*FW +: FW]);
  endfunction

  // Pulse monitor, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (commit) begin
      commit_cnt++;
      commit_f0 = fld(out_values, 0);
    end
    if (abort)    abort_cnt++;
    if (abort_prev) after_abort = out_values;
    abort_prev = abort;
    if (menu_evt) menu_cnt++;
    if (alt_evt)  alt_cnt++;
  end

  task automatic clear_counts();
    commit_cnt  = 0;
    abort_cnt   = 0;
    menu_cnt    = 0;
    alt_cnt     = 0;
    commit_f0   = -1;
    after_abort = '1;
  endtask

  // One clean press: 12 cycles held, then 10 cycles released.
  task automatic press(input logic [4:0] k);
    key = k;
    repeat (12) @(negedge clk);
    key = '0;
    repeat (10) @(negedge clk);
  endtask

  // Hold SET until EDIT_ACTIVE is seen, then release the key.
  task automatic enter_edit(input string tag);
    int n;
    n   = 0;
    key = K_SET;
    while (!edit_active && n < 40) begin
      @(negedge clk);
      n++;
    end
    key = '0;
    check(tag, int'(edit_active), 1);
  endtask

  // Count falling edges until ABORT appears (bounded).
  task automatic cycles_to_abort(output int n);
    n = 0;
    while (!abort && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int d;
    rst_n     = 1'b0;
    key       = '0;
    in_values = {6'd45, 6'd30, 6'd23};
    field_min = '0;
    field_max = {6'd59, 6'd59, 6'd23};
    clear_counts();
    abort_prev = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_edit_active", int'(edit_active), 0);
    check("rst_field_sel",   int'(field_sel),   0);
    check("rst_pulses",      int'({commit, abort, menu_evt, alt_evt}), 0);
    check("rst_out_values",  int'(out_values),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tracks_in", int'(out_values), int'(in_values));

    // Idle key events.
    clear_counts();
    press(K_MENU);
    check("idle_menu_evt", menu_cnt, 1);
    check("idle_menu_alt", alt_cnt,  0);
    clear_counts();
    press(K_CANCEL);
    check("idle_cancel_alt",  alt_cnt,  1);
    check("idle_cancel_menu", menu_cnt, 0);
    press(K_UP);
    check("idle_up_ignored", int'(out_values), int'(in_values));
    check("idle_up_no_edit", int'(edit_active), 0);

    // Two keys together never produce an event.
    clear_counts();
    key = K_UP | K_DOWN;
    repeat (20) @(negedge clk);
    key = '0;
    repeat (10) @(negedge clk);
    check("multi_key_none", menu_cnt + alt_cnt + int'(edit_active), 0);

    // Edit field0 = 23: UP wraps to 0, DOWN wraps to 23, DOWN -> 22, commit.
    press(K_SET);
    check("set_edit_active", int'(edit_active), 1);
    check("set_field_sel",   int'(field_sel),   0);
    press(K_UP);
    check("up_wrap_to_min", fld(out_values, 0), 0);
    press(K_DOWN);
    check("down_wrap_to_max", fld(out_values, 0), 23);
    press(K_DOWN);
    check("down_step", fld(out_values, 0), 22);
    clear_counts();
    press(K_SET);
    check("commit_width",   commit_cnt, 1);
    check("commit_value",   commit_f0,  22);
    check("commit_no_abort", abort_cnt, 0);
    check("commit_exit",    int'(edit_active), 0);
    check("commit_retrack", int'(out_values), int'(in_values));

    // Bounce of 2 cycles, then a long hold: exactly one increment.
    press(K_SET);
    key = K_UP;
    repeat (2) @(negedge clk);
    key = '0;
    @(negedge clk);
    key = K_UP;
    repeat (20) @(negedge clk);
    key = '0;
    repeat (10) @(negedge clk);
    check("bounce_one_inc", fld(out_values, 0), 0);

    // Field selection wraps; DOWN at min wraps; UP then cancel.
    press(K_MENU);
    check("menu_sel_1", int'(field_sel), 1);
    press(K_MENU);
    check("menu_sel_2", int'(field_sel), 2);
    press(K_MENU);
    check("menu_sel_0", int'(field_sel), 0);
    press(K_UP);
    check("edit_before_cancel", fld(out_values, 0), 1);
    clear_counts();
    press(K_CANCEL);
    check("cancel_abort_width", abort_cnt,  1);
    check("cancel_no_commit",   commit_cnt, 0);
    check("cancel_out_next",    int'(after_abort), int'(in_values));
    check("cancel_exit",        int'(edit_active), 0);

    // Idle timeout: ABORT 50 cycles after entering EDIT.
    clear_counts();
    enter_edit("to_enter");
    cycles_to_abort(n);
    check("timeout_cycles", n, 50);
    repeat (3) @(negedge clk);
    check("timeout_abort_width", abort_cnt, 1);
    check("timeout_exit", int'(edit_active), 0);

    // A key landing on the timeout cycle wins and restarts the counter.
    repeat (10) @(negedge clk);
    clear_counts();
    enter_edit("to_key_enter");
    repeat (42) @(negedge clk);
    key = K_MENU;
    n   = 0;
    while (field_sel != 2'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    key = '0;
    check("to_key_accepted", int'(field_sel), 1);
    check("to_key_no_abort", abort_cnt, 0);
    cycles_to_abort(d);
    check("to_key_restart", d, 50);
    repeat (10) @(negedge clk);

    // Clamp on capture; min > max pins the field at min.
    in_values = {6'd45, 6'd62, 6'd23};
    field_min = {6'd50, 6'd0, 6'd0};
    field_max = {6'd10, 6'd59, 6'd23};
    repeat (2) @(negedge clk);
    press(K_SET);
    check("clamp_over_max", fld(out_values, 1), 0);
    check("clamp_in_range", fld(out_values, 0), 23);
    check("clamp_inverted", fld(out_values, 2), 50);
    press(K_MENU);
    press(K_MENU);
    press(K_UP);
    check("inverted_up", fld(out_values, 2), 50);
    press(K_DOWN);
    check("inverted_down", fld(out_values, 2), 50);
    press(K_CANCEL);
    in_values = {6'd45, 6'd30, 6'd23};
    field_min = '0;
    field_max = {6'd59, 6'd59, 6'd23};
    repeat (2) @(negedge clk);

`ifdef AUTO_REPEAT_EN
    // Hold UP on field1 (30): acceptance plus repeats at 10,13,..,25.
    press(K_SET);
    press(K_MENU);
    key = K_UP;
    n   = 0;
    while (fld(out_values, 1) == 30 && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Two synchroniser cycles pass before the release is seen.
    repeat (22) @(negedge clk);
    key = '0;
    repeat (10) @(negedge clk);
    check("repeat_count", fld(out_values, 1), 37);
    press(K_CANCEL);
`endif

    // Reset in the middle of an edit: discarded, no pulses.
    press(K_SET);
    press(K_UP);
    check("mid_rst_in_edit", int'(edit_active), 1);
    clear_counts();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_edit_low", int'(edit_active), 0);
    check("mid_rst_out_zero", int'(out_values),  0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_pulse", commit_cnt + abort_cnt, 0);
    check("mid_rst_retrack",  int'(out_values), int'(in_values));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
